// File: rtl/pc_fetch_pkg.sv
// Shared CPU front-end definitions: fetch FSM encoding, reset PC, redirect payload.
package pc_fetch_pkg;

  localparam int unsigned PCF_XLEN     = 32;
  localparam int unsigned PCF_EXT_W    = 18;
  localparam int unsigned PCF_COMBIN_W = 28;
  localparam int unsigned PCF_STATE_W  = 2;

  localparam logic [PCF_XLEN-1:0] PCF_RESET_PC  = 32'h0000_0000;
  localparam logic [PCF_XLEN-1:0] PCF_INSTR_LEN = 32'd4;
  localparam logic [PCF_XLEN-1:0] PCF_COUNT_MAX = 32'hFFFF_FFFF;

  // Fetch sequencer states
  typedef enum logic [PCF_STATE_W-1:0] {
    PCF_BOOT = 2'd0,
    PCF_RUN  = 2'd1,
    PCF_HALT = 2'd2
  } pcf_state_e;

  // Redirect requests presented by decode/execute in one cycle
  typedef struct packed {
    logic                    halt;
    logic                    jr;
    logic [PCF_XLEN-1:0]     rs;
    logic                    jump;
    logic [PCF_COMBIN_W-1:0] combin;
    logic                    branch;
    logic [PCF_EXT_W-1:0]    ext18;
  } pcf_redirect_t;

  // Sign-extend the word-shifted branch offset to the PC width
  function automatic logic [PCF_XLEN-1:0] pcf_sext18(input logic [PCF_EXT_W-1:0] v);
    return {{(PCF_XLEN - PCF_EXT_W){v[PCF_EXT_W-1]}}, v};
  endfunction

endpackage

// File: rtl/pc_fetch_next.sv
// Stateless next-PC selection for the fetch stage.
module pc_next
  import pc_fetch_pkg::*;
#(
  parameter bit HALT_ON_MISALIGN = 1'b1
) (
  input  logic [PCF_XLEN-1:0] pc,
  input  logic [PCF_XLEN-1:0] pc4,
  input  pcf_redirect_t       redir,
  output logic [PCF_XLEN-1:0] next_pc_c,
  output logic                stop_c,
  output logic                misalign_c
);

  logic                bad_low_c;
  logic [PCF_XLEN-1:0] jr_target_c;
  logic [PCF_XLEN-1:0] j_target_c;
  logic [PCF_XLEN-1:0] br_target_c;

  // Candidate targets; JR low bits are cleared when misalignment is tolerated
  always_comb begin
    bad_low_c   = (redir.rs[1:0] != 2'b00);
    jr_target_c = {redir.rs[PCF_XLEN-1:2], 2'b00};
    j_target_c  = {pc4[PCF_XLEN-1:PCF_COMBIN_W], redir.combin};
    br_target_c = pc4 + pcf_sext18(redir.ext18);
  end

  // Priority: halt, JR, J, branch, sequential
  always_comb begin
    next_pc_c  = pc4;
    stop_c     = 1'b0;
    misalign_c = 1'b0;
    if (redir.halt) begin
      next_pc_c = pc;
      stop_c    = 1'b1;
    end else if (redir.jr) begin
      if (HALT_ON_MISALIGN && bad_low_c) begin
        next_pc_c  = pc;
        stop_c     = 1'b1;
        misalign_c = 1'b1;
      end else begin
        next_pc_c = jr_target_c;
      end
    end else if (redir.jump) begin
      next_pc_c = j_target_c;
    end else if (redir.branch) begin
      next_pc_c = br_target_c;
    end
  end

endmodule

// File: rtl/pc_fetch.sv
// Program counter and fetch sequencer: BOOT -> RUN -> HALT, with stall and redirects.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC         = PCF_RESET_PC,
  parameter bit          HALT_ON_MISALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pcf_install,
  input  logic        pcf_inbranch,
  input  logic [17:0] pcf_inext18,
  input  logic        pcf_injump,
  input  logic [27:0] pcf_incombin,
  input  logic        pcf_injr,
  input  logic [31:0] pcf_inrs,
  input  logic        pcf_inhalt,
  output logic [31:0] pcf_outaddr,
  output logic [31:0] pcf_outpc4,
  output logic        pcf_outvalid,
  output logic        pcf_outhalted,
  output logic        pcf_outerr,
  output logic [31:0] pcf_outcount
);

  pcf_state_e          state_q, state_d;
  logic [PCF_XLEN-1:0] pc_q, pc_d;
  logic [PCF_XLEN-1:0] count_q, count_d;
  logic                err_q, err_d;
  logic                valid_q, valid_d;
  logic                halted_q, halted_d;
  logic                boot_q, boot_d;

  pcf_redirect_t       redir_c;
  logic [PCF_XLEN-1:0] pc4_c;
  logic [PCF_XLEN-1:0] next_pc_c;
  logic                stop_c;
  logic                misalign_c;

  // Bundle the redirect inputs and form the sequential successor
  always_comb begin
    redir_c.halt   = pcf_inhalt;
    redir_c.jr     = pcf_injr;
    redir_c.rs     = pcf_inrs;
    redir_c.jump   = pcf_injump;
    redir_c.combin = pcf_incombin;
    redir_c.branch = pcf_inbranch;
    redir_c.ext18  = pcf_inext18;
    pc4_c          = pc_q + PCF_INSTR_LEN;
  end

  pc_next #(
    .HALT_ON_MISALIGN(HALT_ON_MISALIGN)
  ) u_pc_next (
    .pc         (pc_q),
    .pc4        (pc4_c),
    .redir      (redir_c),
    .next_pc_c  (next_pc_c),
    .stop_c     (stop_c),
    .misalign_c (misalign_c)
  );

  // State register and all fetch-side flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= PCF_BOOT;
      pc_q     <= RESET_PC;
      count_q  <= '0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      boot_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      boot_q   <= boot_d;
    end
  end

  // Next-state and register updates; stall freezes everything in RUN
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    err_d   = err_q;
    boot_d  = boot_q;
    unique case (state_q)
      PCF_BOOT: begin
        // The first edge after reset release only arms the boot flag
        boot_d = 1'b1;
        if (boot_q) begin
          state_d = PCF_RUN;
        end
      end
      PCF_RUN: begin
        if (!pcf_install) begin
          pc_d    = next_pc_c;
          count_d = (count_q == PCF_COUNT_MAX) ? count_q : count_q + 32'd1;
          if (stop_c) begin
            state_d = PCF_HALT;
          end
          if (misalign_c) begin
            err_d = 1'b1;
          end
        end
      end
      PCF_HALT: begin
        state_d = PCF_HALT;
      end
      default: begin
        state_d = PCF_BOOT;
        pc_d    = RESET_PC;
      end
    endcase
    valid_d  = (state_d == PCF_RUN);
    halted_d = (state_d == PCF_HALT);
  end

  // Output mapping; the link value is the only combinational output
  assign pcf_outaddr   = pc_q;
  assign pcf_outpc4    = pc4_c;
  assign pcf_outvalid  = valid_q;
  assign pcf_outhalted = halted_q;
  assign pcf_outerr    = err_q;
  assign pcf_outcount  = count_q;

endmodule
